// File: rtl/pipe_reg_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_reg_stage_pkg
//
// Shared definitions for the pipeline stage register and its skid buffer.
//
//   DATA_LEN  : base datapath width; default for the PC, instruction and
//               performance-counter widths.
//   NOP_INST  : encoding presented on the instruction output whenever the
//               stage holds no valid beat (add x0,x0,x0).
//   buf_state_e : occupancy of the two-entry buffer. The encoding is
//               {main_v, skid_v}, so the state register bits double as the
//               two valid flags and the handshake outputs are read straight
//               off the flops.
// -----------------------------------------------------------------------------
package pipe_reg_stage_pkg;

    localparam int DATA_LEN = 32;

    localparam logic [DATA_LEN-1:0] NOP_INST = 32'h0000_0033;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,   // nothing held
        FULL1 = 2'b10,   // main entry valid, skid entry free
        FULL2 = 2'b11    // both entries valid, upstream is stalled
    } buf_state_e;

    // Bit positions of the valid flags inside buf_state_e.
    localparam int MAIN_V_BIT = 1;
    localparam int SKID_V_BIT = 0;

endpackage : pipe_reg_stage_pkg

// File: rtl/pipe_reg_stage_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
//
// Generic two-entry valid/ready buffer (main + skid) over an opaque W-bit
// payload. The downstream side always sees the main entry; the skid entry only
// catches the beat that arrives while main is stalled. Because in_ready_o is
// the inverse of the skid-valid flop, there is no combinational path from
// out_ready_i to in_ready_o, which lets long pipelines close timing on the
// backward ready chain.
//
// Flush empties both entries on the clock edge where it is sampled. A beat
// accepted on that same edge is consumed and dropped; a pop on that edge is a
// completed transfer.
//
// Ports
//   clk_i        in   rising-edge clock
//   rst_i        in   asynchronous active-low reset
//   flush_i      in   discard everything held and incoming
//   in_valid_i   in   upstream beat valid
//   in_ready_o   out  buffer can accept a beat (registered)
//   in_data_i    in   upstream payload
//   out_valid_o  out  main entry valid
//   out_ready_i  in   downstream accepts the main entry
//   out_data_o   out  main entry payload (holds last value when empty)
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import pipe_reg_stage_pkg::*;
#(
    parameter int W = 2 * DATA_LEN
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    buf_state_e   state_q;
    buf_state_e   state_d;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    logic accept;
    logic pop;
    logic load_main_in;     // main <= incoming beat
    logic load_main_skid;   // main <= skid (skid drains forward, FIFO order)
    logic load_skid;        // skid <= incoming beat

    assign out_valid_o = state_q[MAIN_V_BIT];
    assign in_ready_o  = ~state_q[SKID_V_BIT];
    assign out_data_o  = main_q;

    assign accept = in_valid_i & in_ready_o;
    assign pop    = out_valid_o & out_ready_i;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath load enables.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;

        if (flush_i) begin
            // Flush wins over everything: nothing is loaded, so the main
            // payload (and therefore the PC output) keeps its last value.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d      = FULL1;
                        load_main_in = 1'b1;
                    end
                end
                FULL1: begin
                    if (accept && pop) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_d   = FULL2;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL2: begin
                    // in_ready_o is low here, so no accept can coincide.
                    if (pop) begin
                        state_d        = FULL1;
                        load_main_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // Main entry: visible on the output, so it has a defined reset value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_q <= '0;
        end else if (load_main_in) begin
            main_q <= in_data_i;
        end else if (load_main_skid) begin
            main_q <= skid_q;
        end
    end

    // Skid entry.
    // NOTE: this storage is deliberately left without reset; it is only read
    // when skid_v is set, and skid_v is reset, so its contents never matter
    // before the first write.
    always_ff @(posedge clk_i) begin
        if (load_skid) begin
            skid_q <= in_data_i;
        end
    end

endmodule : pipe_skid_buf

// File: rtl/pipe_reg_stage.sv
// -----------------------------------------------------------------------------
// pipe_reg_stage
//
// Parametrised pipeline stage register for PC/instruction payloads with a
// valid/ready handshake on both sides. Built around pipe_skid_buf, so the
// upstream ready is fully registered and the stage sustains one beat per
// cycle. When the stage holds nothing (after reset, after draining, or after a
// flush) inst_o shows NOP_VAL while pc_o keeps its last value.
//
// Reset assertion is asynchronous; deassertion is expected to be synchronised
// to clk_i by the reset generator.
//
// Optional feature (compile-time macro PIPE_PERF_CNT_EN):
//   stall_cnt_o counts cycles with out_valid_o && !out_ready_i,
//   flush_cnt_o counts cycles with flush_i asserted.
//   Both wrap modulo 2^CNT_W and clear on reset. Without the macro the CNT_W
//   parameter, both ports and both counters do not exist.
//
// Ports
//   clk_i        in   rising-edge clock
//   rst_i        in   asynchronous active-low reset
//   in_valid_i   in   upstream beat valid
//   in_ready_o   out  stage can accept a beat (registered)
//   pc_i         in   upstream PC            [PC_W]
//   inst_i       in   upstream instruction   [INST_W]
//   flush_i      in   kill all held and incoming beats
//   out_valid_o  out  beat presented downstream
//   out_ready_i  in   downstream accepts
//   pc_o         out  held PC                [PC_W]
//   inst_o       out  held instruction, NOP_VAL when out_valid_o=0 [INST_W]
//   stall_cnt_o  out  stall cycle counter    [CNT_W]  (PIPE_PERF_CNT_EN)
//   flush_cnt_o  out  flush counter          [CNT_W]  (PIPE_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module pipe_reg_stage
    import pipe_reg_stage_pkg::*;
#(
    parameter int                PC_W    = DATA_LEN,
    parameter int                INST_W  = DATA_LEN,
    parameter logic [INST_W-1:0] NOP_VAL = INST_W'(NOP_INST)
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int                CNT_W   = DATA_LEN
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [INST_W-1:0] inst_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    localparam int PAYLOAD_W = PC_W + INST_W;

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    // Payload layout: {pc, inst}.
    assign in_payload = {pc_i, inst_i};

    pipe_skid_buf #(
        .W (PAYLOAD_W)
    ) u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_payload),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_payload)
    );

    // The PC keeps its last value when empty so debug/trace logic downstream
    // still sees where the bubble came from; only the instruction is
    // replaced so the next stage executes a harmless NOP.
    assign pc_o   = out_payload[INST_W +: PC_W];
    assign inst_o = out_valid_o ? out_payload[INST_W-1:0] : NOP_VAL;

`ifdef PIPE_PERF_CNT_EN
    logic stall_evt;

    assign stall_evt = out_valid_o & ~out_ready_i;

    // Free-running wrap-around counters; overflow is expected and harmless.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_evt) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_i) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end
`endif

endmodule : pipe_reg_stage

// File: doc/pipe_reg_stage.md
Name: pipe_reg_stage

Overview:
Parametrised pipeline stage register for PC/instruction-style payloads, replacing fixed stall/flush registers between pipeline stages. Uses a valid/ready handshake on both sides with a 2-entry main+skid buffer, so the upstream ready path is fully registered. Flush kills everything in flight and presents a NOP. Sits between any two stages (IF/ID first, ID/EX next).

Parameters:
PC_W, 32, width of the PC field
INST_W, 32, width of the instruction/payload field
NOP_VAL, 32'h0000_0033, value driven on inst_o when the stage is empty or flushed (add x0,x0,x0)
CNT_W, 32, width of the performance counters (optional feature only)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
in_valid_i  in  1  upstream beat valid
in_ready_o  out  1  stage can accept a beat
pc_i  in  PC_W  upstream PC
inst_i  in  INST_W  upstream instruction
flush_i  in  1  kill all held and incoming beats
out_valid_o  out  1  beat presented downstream
out_ready_i  in  1  downstream accepts
pc_o  out  PC_W  held PC
inst_o  out  INST_W  held instruction; NOP_VAL when out_valid_o=0
stall_cnt_o  out  CNT_W  stall cycles (PIPE_PERF_CNT_EN only)
flush_cnt_o  out  CNT_W  flushes (PIPE_PERF_CNT_EN only)

Behaviour:
- Reset (rst_i=0, async): main_v=0, skid_v=0, pc_o=0, inst_o=NOP_VAL, in_ready_o=1, counters=0. Deassertion is synchronous to clk_i.
- Accept: in_valid_i && in_ready_o. Pop: out_valid_o && out_ready_i.
- out_valid_o = main_v. in_ready_o = !skid_v, taken directly from a flop with no combinational path from out_ready_i.
- Latency: an accepted beat reaches pc_o/inst_o on the next edge if main is empty or popping. Throughput is 1 beat/cycle.
- States (main_v,skid_v):
  - EMPTY(0,0): accept -> FULL1.
  - FULL1(1,0):
    - accept&&pop -> FULL1 with new data.
    - accept&&!pop -> FULL2, input goes to skid.
    - pop&&!accept -> EMPTY.
  - FULL2(1,1): in_ready_o=0. pop -> FULL1 with skid moved to main.
- Ordering is strictly FIFO. Skid data never overtakes main.
- Empty output: when main_v=0, inst_o=NOP_VAL and pc_o holds its last value.
- Flush has priority over all events. On the edge with flush_i=1:
  - main_v=0, skid_v=0, inst_o=NOP_VAL, pc_o unchanged.
  - Any simultaneous accepted beat is consumed and dropped.
  - Any simultaneous pop is still a completed downstream transfer.
- in_ready_o=1 in the cycle after a flush.
- out_ready_i is ignored while out_valid_o=0.
- Data inputs are ignored when in_valid_i=0.
- Reset mid-operation: held beats are lost and outputs return to reset values immediately.

Optional Feature:
Macro PIPE_PERF_CNT_EN.
- Defined:
  - stall_cnt_o increments each cycle with out_valid_o && !out_ready_i.
  - flush_cnt_o increments each cycle with flush_i=1.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both ports and counters are absent, and there is no area cost.

Decomposition:
- Shared package (Define.v style header):
  - DATA_LEN-based default widths.
  - NOP encoding constant.
  - State encodings EMPTY/FULL1/FULL2.
- Natural sub-module: pipe_skid_buf, a generic valid/ready 2-entry buffer over a concatenated {pc,inst} vector.
- pipe_reg_stage wraps pipe_skid_buf with NOP substitution, flush, and counters.

Test Plan:
1. Reset then idle: rst_i=0 mid-cycle -> out_valid_o=0, inst_o=32'h33, pc_o=0, in_ready_o=1 without waiting for a clock edge.
2. Streaming: out_ready_i=1; beats pc=0x0,0x4,0x8 with inst 0xA,0xB,0xC on consecutive cycles -> same sequence on outputs one cycle later, no bubbles.
3. Backpressure/skid: out_ready_i=0; send pc=0x10, then 0x14 -> in_ready_o=0 after the 2nd accept. Raise out_ready_i -> 0x10 then 0x14 appear in order, and in_ready_o=1 after the first pop.
4. Flush in FULL2 with a simultaneous in_valid_i beat pc=0x20 -> next cycle out_valid_o=0, inst_o=0x33, in_ready_o=1. 0x20 never appears.
5. Flush with simultaneous pop: main holds 0x30, out_ready_i=1, flush_i=1 -> 0x30 counted as transferred, stage empty next cycle.
6. With PIPE_PERF_CNT_EN: 5 cycles of out_valid_o=1 with out_ready_i=0, then 2 flushes -> stall_cnt_o=5, flush_cnt_o=2. Preload the counters near all-ones to confirm they wrap to 0.
